ml_sched: RTL and testbench

- Job scheduler and result collector for the ML detection datapath.
- Accepts (y_hat, R) jobs from the QR stage into a 2-entry ping-pong buffer.
- Issues a one-cycle trigger plus operands to the ML datapath, then monitors its candidate counter and per-candidate metric stream.
- Returns the minimum-metric candidate index and value through a valid/ready output; the QR stage can fill the next job while the current one runs.

---
 rtl/ml_sched.sv | 147 ++++++++++++++
 tb/tb_ml_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ml_sched.sv
// rtl/ml_sched.sv - ML detection job scheduler with 2-entry ping-pong buffer and min-metric collector
// Optional macro ML_TIMEOUT_EN adds a watchdog that aborts a job after TIMEOUT cycles (o_err=1).
module ml_sched #(
  parameter int METRIC_W = 24,
  parameter int NUM_CAND = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [159:0]        i_y_hat,
  input  logic [319:0]        i_r,
  output logic                o_dp_trig,
  output logic [159:0]        o_dp_y_hat,
  output logic [319:0]        o_dp_r,
  input  logic                i_dp_cu_en,
  input  logic [5:0]          i_dp_cnt,
  input  logic                i_metric_valid,
  input  logic [METRIC_W-1:0] i_metric,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [5:0]          o_best_idx,
  output logic [METRIC_W-1:0] o_best_metric,
  output logic                o_err,
  output logic                o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_EN, S_RUN, S_DONE} state_t;

  localparam logic [5:0] LAST_CNT = 6'(NUM_CAND - 1);

  if (NUM_CAND < 1 || NUM_CAND > 64 || TIMEOUT < 2) begin : g_param_err
    $error("ml_sched: NUM_CAND must be 1..64 and TIMEOUT at least 2");
  end

  state_t                state_q, state_d;
  logic [159:0]          y_mem_q [2];
  logic [319:0]          r_mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic [5:0]            cnt_q;
  logic [5:0]            best_idx_q;
  logic [METRIC_W-1:0]   best_metric_q;
  logic                  push, pop, metric_fire, last_metric, tmo_hit;

  assign o_in_ready  = i_rst_n & (occ_q != 2'd2);
  assign push        = i_in_valid & o_in_ready;
  assign pop         = (state_q == S_TRIG);
  assign metric_fire = i_metric_valid & ((state_q == S_WAIT_EN) | (state_q == S_RUN));
  assign last_metric = metric_fire & (cnt_q == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (push) begin
      y_mem_q[wr_ptr_q] <= i_y_hat;
      r_mem_q[wr_ptr_q] <= i_r;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 6'd0;
      best_idx_q    <= 6'd0;
      best_metric_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_TRIG) begin
        cnt_q         <= 6'd0;
        best_idx_q    <= 6'd0;
        best_metric_q <= '1;
      end else if (metric_fire) begin
        cnt_q <= cnt_q + 6'd1;
        // Strict compare: on ties the earlier candidate is kept.
        if (i_metric < best_metric_q) begin
          best_metric_q <= i_metric;
          best_idx_q    <= i_dp_cnt;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (occ_q != 2'd0) state_d = S_TRIG;
      S_TRIG:    state_d = S_WAIT_EN;
      S_WAIT_EN: begin
        if (last_metric || tmo_hit) state_d = S_DONE;
        else if (i_dp_cu_en)        state_d = S_RUN;
      end
      S_RUN:     if (last_metric || tmo_hit) state_d = S_DONE;
      S_DONE:    if (i_out_ready) state_d = (occ_q != 2'd0) ? S_TRIG : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef ML_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // tmo_q is 0 on the first cycle after TRIG, so DONE lands exactly TIMEOUT cycles after TRIG.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 2));
  assign o_err   = (state_q == S_DONE) & err_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_TRIG) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if ((state_q == S_WAIT_EN) || (state_q == S_RUN)) begin
      tmo_q <= tmo_q + 1'b1;
      if (tmo_hit && !last_metric) err_q <= 1'b1;
    end else if ((state_q == S_DONE) && i_out_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign o_err   = 1'b0;
`endif

  assign o_dp_trig     = (state_q == S_TRIG);
  assign o_dp_y_hat    = o_dp_trig ? y_mem_q[rd_ptr_q] : '0;
  assign o_dp_r        = o_dp_trig ? r_mem_q[rd_ptr_q] : '0;
  assign o_out_valid   = (state_q == S_DONE);
  assign o_best_idx    = o_out_valid ? best_idx_q : 6'd0;
  assign o_best_metric = o_out_valid ? best_metric_q : '0;
  assign o_busy        = (state_q != S_IDLE) | (occ_q != 2'd0);

endmodule

// File: tb/tb_ml_sched.sv
// tb/tb_ml_sched.sv - directed self-checking bench for ml_sched
module tb_ml_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] y_hat;
  logic [319:0] r;
  logic         dp_trig;
  logic [159:0] dp_y_hat;
  logic [319:0] dp_r;
  logic         cu_en;
  logic [5:0]   dp_cnt;
  logic         m_valid;
  logic [23:0]  metric;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   best_idx;
  logic [23:0]  best_metric;
  logic         err;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ml_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_y_hat(y_hat), .i_r(r), .o_dp_trig(dp_trig), .o_dp_y_hat(dp_y_hat), .o_dp_r(dp_r),
    .i_dp_cu_en(cu_en), .i_dp_cnt(dp_cnt), .i_metric_valid(m_valid), .i_metric(metric),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_best_idx(best_idx),
    .o_best_metric(best_metric), .o_err(err), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] gen_y(input logic [7:0] id);
    return {20{id}};
  endfunction

  function automatic logic [319:0] gen_r(input logic [7:0] id);
    return {40{id ^ 8'h5A}};
  endfunction

  function automatic logic [23:0] mval(input int pat, input int k);
    case (pat)
      0: return 24'(100 - k);
      1: return 24'd5;
      2: return (k == 17) ? 24'd3 : 24'd50;
      3: return 24'(k + 10);
      4: return (k < 20) ? 24'(40 - k) : 24'd40;
      default: return (k == 5) ? 24'd7 : 24'd9;
    endcase
  endfunction

  task automatic set_job(input logic [7:0] id);
    y_hat = gen_y(id);
    r     = gen_r(id);
  endtask

  task automatic send_metrics(input int pat, input int n);
    cu_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      m_valid = 1'b1;
      dp_cnt  = 6'(k);
      metric  = mval(pat, k);
      if (k == n - 1) chk("valid_before_last", out_valid, 0);
      tick();
    end
    m_valid = 1'b0;
    cu_en   = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [5:0] idx, input logic [23:0] m);
    chk(tag, {out_valid, err, best_idx, best_metric}, {1'b1, 1'b0, idx, m});
  endtask

  initial begin
    int t;
    int seen_valid;
    int seen_trig;
    rst_n = 1'b0; in_valid = 1'b0; y_hat = '0; r = '0; cu_en = 1'b0;
    dp_cnt = '0; m_valid = 1'b0; metric = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_outputs", {in_ready, dp_trig, out_valid, err, busy, best_idx, best_metric},
        '0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // single job, descending metrics
    in_valid = 1'b1; set_job(8'h11);
    tick();
    in_valid = 1'b0;
    chk("no_trig_1cyc", dp_trig, 0);
    tick();
    chk("trig_2cyc", {dp_trig, dp_y_hat, dp_r}, {1'b1, gen_y(8'h11), gen_r(8'h11)});
    tick();
    chk("trig_one_cycle", dp_trig, 0);
    send_metrics(0, 32);
    chk_result("desc_result", 6'd31, 24'd69);
    tick();
    chk("desc_back_idle", {out_valid, busy}, 0);

    // ties keep earliest candidate
    in_valid = 1'b1; set_job(8'h22);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    send_metrics(1, 32);
    chk_result("tie_result", 6'd0, 24'd5);
    tick();

    // back-to-back three jobs
    in_valid = 1'b1; set_job(8'h31);
    tick();
    set_job(8'h32);
    tick();
    set_job(8'h33);
    chk("b2b_full_stall", {in_ready, dp_trig, dp_y_hat}, {1'b0, 1'b1, gen_y(8'h31)});
    tick();
    chk("b2b_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    send_metrics(2, 32);
    chk_result("b2b_res_a", 6'd17, 24'd3);
    tick();
    chk("b2b_trig_b", {dp_trig, dp_y_hat}, {1'b1, gen_y(8'h32)});
    tick();
    send_metrics(3, 32);
    chk_result("b2b_res_b", 6'd0, 24'd10);
    tick();
    chk("b2b_trig_c", {dp_trig, dp_y_hat, dp_r}, {1'b1, gen_y(8'h33), gen_r(8'h33)});
    tick();
    send_metrics(4, 32);
    chk_result("b2b_res_c", 6'd19, 24'd21);
    tick();
    chk("b2b_idle", busy, 0);

    // backpressure in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; set_job(8'h41);
    tick();
    set_job(8'h42);
    tick();
    in_valid = 1'b0;
    chk("bp_trig_d", {dp_trig, dp_y_hat}, {1'b1, gen_y(8'h41)});
    tick();
    send_metrics(5, 32);
    for (int i = 0; i < 10; i++) begin
      chk("bp_stable", {out_valid, dp_trig, best_idx, best_metric}, {1'b1, 1'b0, 6'd5, 24'd7});
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_trig_e", {dp_trig, dp_y_hat}, {1'b1, gen_y(8'h42)});
    tick();

    // reset mid-RUN with one job buffered
    in_valid = 1'b1; set_job(8'h51);
    tick();
    in_valid = 1'b0;
    send_metrics(0, 12);
    rst_n = 1'b0;
    tick();
    chk("midrun_rst", {in_ready, dp_trig, dp_y_hat, out_valid, err, busy, best_idx, best_metric},
        '0);
    rst_n = 1'b1;
    seen_valid = 0; seen_trig = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid) seen_valid++;
      if (dp_trig) seen_trig++;
    end
    chk("midrun_no_output", {seen_valid, seen_trig}, 0);

    // watchdog: only 10 metrics
    in_valid = 1'b1; set_job(8'h61);
    tick();
    in_valid = 1'b0;
    tick();
    chk("tmo_trig", dp_trig, 1);
    t = 0;
    cu_en = 1'b1;
    while (t < 200 && !out_valid) begin
      m_valid = (t >= 1 && t <= 10);
      dp_cnt  = 6'(t - 1);
      metric  = 24'(60 - (t - 1));
      tick();
      t++;
    end
    m_valid = 1'b0; cu_en = 1'b0;
`ifdef ML_TIMEOUT_EN
    chk("tmo_cycle", t, 64);
    chk("tmo_result", {out_valid, err, best_idx, best_metric}, {1'b1, 1'b1, 6'd9, 24'd51});
    tick();
    chk("tmo_err_clear", {out_valid, err}, 0);
`else
    chk("no_tmo_result", {out_valid, err, busy}, {1'b0, 1'b0, 1'b1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
